// File: rtl/hiscore_pkg.sv
// rtl/hiscore_pkg.sv - shared types and widths for the hiscore RAM arbiter
package hiscore_pkg;

  localparam int HS_ADDR_W = 10;
  localparam int HS_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OWN  = 2'd2,
    REL  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [HS_ADDR_W-1:0] addr;
    logic [HS_DATA_W-1:0] data;
  } hs_wr_t;

endpackage

// File: rtl/hiscore_wr_fifo.sv
// rtl/hiscore_wr_fifo.sv - synchronous buffer for hiscore write pulses
module hiscore_wr_fifo
  import hiscore_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  hs_wr_t din,
  input  logic   pop,
  output hs_wr_t head,
  output logic   full,
  output logic   empty
);

  localparam int IDX_W = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [IDX_W:0] wr_ptr;
  logic [IDX_W:0] rd_ptr;
  hs_wr_t         mem [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign do_pop  = pop && !empty;
  // A full buffer still takes a write when an entry leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[IDX_W-1:0]];

  // Pointer advance; reset discards anything still queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= din;
  end

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// rtl/hiscore_ram_arbiter.sv - CPU/hiscore work-RAM port arbiter; HISCORE_TIMEOUT_EN adds forced grant
module hiscore_ram_arbiter
  import hiscore_pkg::*;
#(
  parameter int ADDR_W         = HS_ADDR_W,
  parameter int DATA_W         = HS_DATA_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int RELEASE_CYCLES = 2,
  parameter int PAUSE_TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] hs_ram_addr,
  input  logic [DATA_W-1:0] hs_ram_data,
  input  logic              hs_ram_write,
  input  logic              hs_rd_en,
  input  logic              ioctl_upload,
  output logic [DATA_W-1:0] hs_din,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_idle,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              pause_cpu,
  output logic              hs_grant,
  output logic              overflow,
  output logic              timeout_err
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_OWN  = OWN;
  localparam logic [1:0] ST_REL  = REL;
  localparam int         REL_W   = $clog2(RELEASE_CYCLES + 2);

  logic [1:0]       state;
  logic [REL_W-1:0] rel_cnt;
  hs_wr_t           wr_in;
  hs_wr_t           wr_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             req;
  logic             rd_q;
  logic             timeout_hit;

  assign wr_in.addr = hs_ram_addr;
  assign wr_in.data = hs_ram_data;

  hiscore_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (hs_ram_write),
    .din     (wr_in),
    .pop     (fifo_pop),
    .head    (wr_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign req       = !fifo_empty || hs_rd_en || ioctl_upload;
  assign pause_cpu = (state != ST_IDLE);
  assign hs_grant  = (state == ST_OWN);
  assign fifo_pop  = hs_grant && !fifo_empty;

`ifdef HISCORE_TIMEOUT_EN
  localparam int TO_W = $clog2(PAUSE_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_err_q;

  assign timeout_hit = (state == ST_REQ) && !cpu_idle &&
                       (to_cnt == TO_W'(PAUSE_TIMEOUT - 1));
  assign timeout_err = to_err_q;

  // Count cycles spent waiting in REQ; a forced grant latches the error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt   <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (state != ST_REQ) to_cnt <= '0;
      else                 to_cnt <= to_cnt + 1'b1;
      if (timeout_hit && req) to_err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (PAUSE_TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  // Arbitration: CPU until it idles, hiscore while work remains, then a pause tail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      rel_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req) state <= ST_REQ;
        ST_REQ: begin
          if (!req)                         state <= ST_IDLE;
          else if (cpu_idle || timeout_hit) state <= ST_OWN;
        end
        ST_OWN: begin
          if (!req) begin
            state   <= ST_REL;
            rel_cnt <= REL_W'(RELEASE_CYCLES);
          end
        end
        ST_REL: begin
          if (req)                          state   <= ST_OWN;
          else if (rel_cnt <= REL_W'(1))    state   <= ST_IDLE;
          else                              rel_cnt <= rel_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM port mux: buffered writes first, then hiscore reads; CPU frozen in OWN/REL.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = 1'b0;
    case (state)
      ST_IDLE, ST_REQ: ram_we = cpu_we;
      ST_OWN: begin
        if (!fifo_empty) begin
          ram_addr  = wr_head.addr;
          ram_wdata = wr_head.data;
          ram_we    = 1'b1;
        end else begin
          ram_addr  = hs_ram_addr;
          ram_wdata = hs_ram_data;
        end
      end
      default: ram_we = 1'b0;
    endcase
  end

  // A granted read issued last cycle has its RAM data now; otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q   <= 1'b0;
      hs_din <= '0;
    end else begin
      rd_q <= hs_grant && fifo_empty && (hs_rd_en || ioctl_upload);
      if (rd_q) hs_din <= ram_rdata;
    end
  end

  // Sticky flag for a write pulse that found no room.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                      overflow <= 1'b0;
    else if (hs_ram_write && fifo_full && !fifo_pop)   overflow <= 1'b1;
  end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// tb/tb_hiscore_ram_arbiter.sv - randomized self-checking bench for hiscore_ram_arbiter
module tb_hiscore_ram_arbiter;

  logic       clk;
  logic       reset_n;
  logic [9:0] hs_ram_addr;
  logic [7:0] hs_ram_data;
  logic       hs_ram_write;
  logic       hs_rd_en;
  logic       ioctl_upload;
  logic [7:0] hs_din;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_we;
  logic       cpu_idle;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_rdata;
  logic       pause_cpu;
  logic       hs_grant;
  logic       overflow;
  logic       timeout_err;

  hiscore_ram_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hs_ram_addr  (hs_ram_addr),
    .hs_ram_data  (hs_ram_data),
    .hs_ram_write (hs_ram_write),
    .hs_rd_en     (hs_rd_en),
    .ioctl_upload (ioctl_upload),
    .hs_din       (hs_din),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_we       (cpu_we),
    .cpu_idle     (cpu_idle),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_rdata    (ram_rdata),
    .pause_cpu    (pause_cpu),
    .hs_grant     (hs_grant),
    .overflow     (overflow),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Work RAM: synchronous read, one cycle latency.
  logic [7:0] ram_mem [1024];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Reference: contents written by the hiscore engine, expected write order,
  // buffer occupancy while the CPU is still running, sticky overflow.
  logic [7:0]  model_mem [int];
  logic [17:0] exp_q [$];
  logic [17:0] got_q [$];
  int          occ;
  bit          exp_ovf;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One write pulse; only valid while nothing drains (CPU not idle).
  task automatic push_one(input logic [9:0] a, input logic [7:0] d, input bit upd);
    hs_ram_addr  = a;
    hs_ram_data  = d;
    hs_ram_write = 1'b1;
    if (occ < 4) begin
      exp_q.push_back({a, d});
      occ++;
      if (upd) model_mem[a] = d;
    end else begin
      exp_ovf = 1'b1;
    end
    @(negedge clk);
    hs_ram_write = 1'b0;
  endtask

  task automatic drain(output int nw, output int rel, output int span);
    int  first;
    int  last;
    bit  seen;
    nw = 0; rel = 0; first = 0; last = 0; seen = 0;
    cpu_idle = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (hs_grant) seen = 1'b1;
      if (hs_grant && ram_we) begin
        got_q.push_back({ram_addr, ram_wdata});
        if (nw == 0) first = cyc;
        last = cyc;
        nw++;
      end
      if (seen && pause_cpu && !hs_grant) rel++;
      if (seen && !pause_cpu) break;
    end
    chk("drain_done", {31'd0, seen && !pause_cpu}, 32'd1);
    cpu_idle = 1'b0;
    span = last - first;
  endtask

  task automatic check_drain();
    int nw;
    int rel;
    int span;
    drain(nw, rel, span);
    chk("n_writes", nw, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("wr_order", got_q[i], exp_q[i]);
    chk("rel_len", rel, 2);
    if (nw > 0) chk("wr_consec", span, nw - 1);
    chk("overflow", overflow, exp_ovf);
    chk("pause_low", pause_cpu, 0);
    exp_q.delete();
    got_q.delete();
    occ = 0;
  endtask

  task automatic rd_check(input logic [9:0] a);
    bit ok;
    ok = 1'b0;
    hs_ram_addr = a;
    hs_rd_en    = 1'b1;
    cpu_idle    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hs_grant) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rd_grant", ok, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rd_data", hs_din, model_mem[a]);
    hs_rd_en    = 1'b0;
    hs_ram_addr = 10'($urandom);
    for (int i = 0; i < 20 && pause_cpu; i++) @(negedge clk);
    chk("rd_release", pause_cpu, 0);
    chk("rd_hold", hs_din, model_mem[a]);
    cpu_idle = 1'b0;
  endtask

  initial begin
    logic [9:0] a;
    logic [9:0] keep_a;
    int         n;
    int         k;
    int         nw;
    int         first_k;
    int         last_k;
    int         drops;
    bit         ok;
    bit         bad;

    n_cmp = 0; n_err = 0; occ = 0; exp_ovf = 1'b0;
    reset_n = 1'b0; hs_ram_addr = '0; hs_ram_data = '0; hs_ram_write = 1'b0;
    hs_rd_en = 1'b0; ioctl_upload = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_we = 1'b0; cpu_idle = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pause", pause_cpu, 0);
    chk("rst_grant", hs_grant, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_din", hs_din, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_to", timeout_err, 0);
    reset_n = 1'b1;

    // CPU owns the port while the hiscore side is quiet.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_addr  = (i == 0) ? 10'h155 : 10'($urandom_range(10'h300, 10'h3FF));
      cpu_wdata = 8'($urandom);
      cpu_we    = 1'b1;
      #1;
      chk("idle_addr", ram_addr, cpu_addr);
      chk("idle_data", ram_wdata, cpu_wdata);
      chk("idle_we", ram_we, 1);
      chk("idle_pause", pause_cpu, 0);
    end
    @(negedge clk);
    cpu_we = 1'b0;

    // Three writes, CPU busy for 5 clocks before idling.
    push_one(10'h00B, 8'h10, 1);
    push_one(10'h00C, 8'h20, 1);
    push_one(10'h00D, 8'h30, 1);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (!pause_cpu || hs_grant) bad = 1'b1;
    end
    chk("wait_req", bad, 0);
    check_drain();

    // Validation read.
    push_one(10'h023, 8'h0F, 1);
    check_drain();
    rd_check(10'h023);

    // Random bursts of 1..6 pulses, drain, then read one back.
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 6);
      keep_a = 10'($urandom_range(10'h100, 10'h2FF));
      for (int j = 0; j < n; j++) begin
        a = (j == 0) ? keep_a : 10'($urandom_range(10'h100, 10'h2FF));
        push_one(a, 8'($urandom), 1);
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      check_drain();
      rd_check(keep_a);
    end

    // Five back-to-back pulses with the CPU busy: only four fit.
    for (int j = 0; j < 5; j++) push_one(10'(10'h060 + j), 8'(8'hA0 + j), 1);
    @(negedge clk);
    chk("ovf5", overflow, 1);
    check_drain();

    // Upload requested while writes are pending.
    push_one(10'h040, 8'($urandom), 1);
    push_one(10'h041, 8'($urandom), 1);
    push_one(10'h042, 8'($urandom), 1);
    ioctl_upload = 1'b1;
    hs_ram_addr  = 10'h041;
    cpu_idle     = 1'b1;
    k = -1; nw = 0; first_k = -1; last_k = -1; drops = 0;
    for (int cyc = 0; cyc < 40 && k < 7; cyc++) begin
      @(negedge clk);
      if (hs_grant && k < 0) k = 0;
      else if (k >= 0) k++;
      if (k >= 0 && !hs_grant) drops++;
      if (hs_grant && ram_we) begin
        got_q.push_back({ram_addr, ram_wdata});
        if (nw == 0) first_k = k;
        last_k = k;
        nw++;
      end
    end
    chk("up_nw", nw, 3);
    chk("up_first", first_k, 0);
    chk("up_last", last_k, 2);
    chk("up_drops", drops, 0);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("up_order", got_q[i], exp_q[i]);
    chk("up_din", hs_din, model_mem[10'h041]);
    hs_ram_addr = 10'h040;
    @(negedge clk);
    @(negedge clk);
    chk("up_din2", hs_din, model_mem[10'h040]);
    chk("up_grant", hs_grant, 1);
    ioctl_upload = 1'b0;
    for (int i = 0; i < 20 && pause_cpu; i++) @(negedge clk);
    chk("up_release", pause_cpu, 0);
    cpu_idle = 1'b0;
    exp_q.delete(); got_q.delete(); occ = 0;

    // Reset during a drain with two entries still queued.
    for (int j = 0; j < 4; j++) push_one(10'(10'h380 + j), 8'($urandom), 0);
    cpu_idle = 1'b1;
    nw = 0; ok = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (hs_grant && ram_we) nw++;
      if (nw == 2) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_mid_reach", ok, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_pause", pause_cpu, 0);
    chk("rst_mid_grant", hs_grant, 0);
    chk("rst_mid_ovf", overflow, 0);
    exp_q.delete(); occ = 0; exp_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ram_we || pause_cpu) bad = 1'b1;
    end
    chk("rst_mid_quiet", bad, 0);
    cpu_idle = 1'b0;

`ifdef HISCORE_TIMEOUT_EN
    // CPU never idles: grant is forced after the timeout.
    push_one(10'h3F0, 8'h11, 1);
    n = 0; ok = 1'b0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(negedge clk);
      n++;
      if (hs_grant) begin
        ok = 1'b1;
        break;
      end
    end
    chk("to_grant", ok, 1);
    chk("to_lat", {31'd0, (n >= 1020) && (n <= 1030)}, 1);
    chk("to_err", timeout_err, 1);
    check_drain();
`else
    chk("to_err_tied", timeout_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
